// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset release sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    DELAY = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Index counters still need one bit when there is only a single stage.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_sync_async.sv
// Reset synchronizer: asserts asynchronously on arst, deasserts SYNC_STAGES clk edges later.
module rst_sync_async #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ff <= '1;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/rst_release_seq.sv
// Synchronises the generator reset and releases NSTAGE reset domains in a timed order.
// Define RSTSEQ_LOCK_EN to return sset/srst end-flag lock pulses to the generator.
module rst_release_seq
  import rst_seq_pkg::*;
#(
  parameter int NSTAGE      = 4,
  parameter int STAGE_DLY   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              grst,
  input  logic              rst_in,
  input  logic              sw_rst_req,
  output logic [NSTAGE-1:0] stage_rst_n,
  output logic              busy,
  output logic              done,
  output logic              sset,
  output logic              srst
);

  localparam int CW = $clog2(STAGE_DLY + 1);
  localparam int IW = clog2_min1(NSTAGE);
  localparam logic [CW-1:0] CNT_LAST = CW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NSTAGE - 1);

  logic              sync_arst;
  logic              rst_s;
  logic              arst;
  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [IW-1:0]     idx, idx_next;
  logic [NSTAGE-1:0] stage_next;

  assign sync_arst = grst | rst_in;

  rst_sync_async #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .arst(sync_arst),
    .q   (rst_s)
  );

  // rst_s comes from a flop, so this reset is glitch-free and releases synchronously;
  // holding the whole FSM in it gives HOLD priority over any other transition.
  assign arst = grst | rst_s;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      stage_rst_n <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      idx         <= idx_next;
      stage_rst_n <= stage_next;
      busy        <= (state_next != DONE);
      done        <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    stage_next = stage_rst_n;
    case (state)
      HOLD: begin
        state_next = DELAY;
        cnt_next   = '0;
        idx_next   = '0;
        stage_next = '0;
      end
      DELAY: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          for (int i = 0; i < NSTAGE; i++) begin
            if (IW'(i) == idx) stage_next[i] = 1'b1;
          end
          if (idx == IDX_LAST) state_next = DONE;
          else                 idx_next   = idx + IW'(1);
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      DONE: begin
        if (sw_rst_req) begin
          state_next = DELAY;
          cnt_next   = '0;
          idx_next   = '0;
          stage_next = '0;
        end
      end
      default: state_next = HOLD;
    endcase
  end

`ifdef RSTSEQ_LOCK_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sset <= 1'b0;
      srst <= 1'b0;
    end else begin
      sset <= (state == DELAY) && (state_next == DONE);
      srst <= (state == DONE) && (state_next == DELAY);
    end
  end
`else
  assign sset = 1'b0;
  assign srst = 1'b0;
`endif

endmodule
